dcache_direct: RTL

Direct-mapped, write-back, write-allocate data cache between the MIPS pipeline's MEM stage and external data memory. It is the responder for the `proc_stall` signal consumed by every pipeline register: it serves load/store hits in the same cycle and holds the pipeline during miss handling. Toward memory it is the initiator of a block-wide read/write handshake closed by `mem_ready`.

---
 rtl/dcache_pkg.sv | 7 +
 rtl/dcache_line_array.sv | 50 +++++
 rtl/dcache_direct.sv | 101 ++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared state encoding and geometry constants for the direct-mapped data cache
package dcache_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, WRITEBACK = 2'd1, ALLOCATE = 2'd2} state_t;
    localparam int OFF_W = 2;
    localparam int LINE_W = 128;
    localparam int TAG_W = 30 - 3 - OFF_W;
endpackage

// File: rtl/dcache_line_array.sv
// dcache_line_array: valid/dirty/tag/data storage with async read and one word-or-fill write port
module dcache_line_array
    import dcache_pkg::*;
#(
    parameter int SETS = 8,
    parameter int IDX_W = 3,
    parameter int TW = TAG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  idx,
    output logic              valid,
    output logic              dirty,
    output logic [TW-1:0]     tag,
    output logic [LINE_W-1:0] line,
    input  logic              word_we,
    input  logic [OFF_W-1:0]  off,
    input  logic [31:0]       word,
    input  logic              fill_we,
    input  logic [TW-1:0]     fill_tag,
    input  logic [LINE_W-1:0] fill_line
);
    logic [SETS-1:0]   v_q;
    logic [SETS-1:0]   d_q;
    logic [TW-1:0]     tag_q  [SETS];
    logic [LINE_W-1:0] data_q [SETS];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            v_q <= '0;
            d_q <= '0;
        end else if (fill_we) begin
            v_q[idx] <= 1'b1;
            d_q[idx] <= 1'b0;
        end else if (word_we)
            d_q[idx] <= 1'b1;

    // tag and data carry no reset so they can map onto plain RAM
    always_ff @(posedge clk)
        if (fill_we) begin
            tag_q[idx]  <= fill_tag;
            data_q[idx] <= fill_line;
        end else if (word_we)
            data_q[idx][{off, 5'b0} +: 32] <= word;

    assign valid = v_q[idx];
    assign dirty = d_q[idx];
    assign tag   = tag_q[idx];
    assign line  = data_q[idx];
endmodule

// File: rtl/dcache_direct.sv
// dcache_direct: direct-mapped write-back write-allocate data cache with block-wide memory handshake
module dcache_direct
    import dcache_pkg::*;
#(
    parameter int SETS = 8,
    parameter int IDX_W = 3,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 proc_read,
    input  logic                 proc_write,
    input  logic [29:0]          proc_addr,
    input  logic [31:0]          proc_wdata,
    output logic                 proc_stall,
    output logic [31:0]          proc_rdata,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [27:0]          mem_addr,
    output logic [WORDS*32-1:0]  mem_wdata,
    input  logic [WORDS*32-1:0]  mem_rdata,
    input  logic                 mem_ready
);
    localparam int TW = 30 - IDX_W - OFF_W;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [TW-1:0]     tag;
    logic [OFF_W-1:0]  off;
    logic              valid;
    logic              dirty;
    logic [TW-1:0]     line_tag;
    logic [LINE_W-1:0] line;
    logic              active;
    logic              hit;
    logic              idle;

    assign idx    = proc_addr[IDX_W+1:2];
    assign tag    = proc_addr[29:IDX_W+2];
    assign off    = proc_addr[1:0];
    assign active = proc_read | proc_write;
    assign hit    = valid && line_tag == tag;
    assign idle   = state == IDLE;

    assign proc_stall = !idle || (active && !hit);
    assign proc_rdata = (idle && active && hit) ? line[{off, 5'b0} +: 32] : '0;

    dcache_line_array #(.SETS(SETS), .IDX_W(IDX_W), .TW(TW)) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .idx       (idx),
        .valid     (valid),
        .dirty     (dirty),
        .tag       (line_tag),
        .line      (line),
        .word_we   (idle && proc_write && hit),
        .off       (off),
        .word      (proc_wdata),
        .fill_we   (state == ALLOCATE && mem_ready),
        .fill_tag  (tag),
        .fill_line (mem_rdata)
    );

    // a store that missed finishes as an ordinary write hit once the fill lands
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else
            case (state)
                IDLE:
                    if (active && !hit) begin
                        if (valid && dirty) begin
                            state     <= WRITEBACK;
                            mem_write <= 1'b1;
                            mem_addr  <= {line_tag, idx};
                            mem_wdata <= line;
                        end else begin
                            state    <= ALLOCATE;
                            mem_read <= 1'b1;
                            mem_addr <= proc_addr[29:2];
                        end
                    end
                WRITEBACK:
                    if (mem_ready) begin
                        state     <= ALLOCATE;
                        mem_write <= 1'b0;
                        mem_read  <= 1'b1;
                        mem_addr  <= proc_addr[29:2];
                    end
                ALLOCATE:
                    if (mem_ready) begin
                        state    <= IDLE;
                        mem_read <= 1'b0;
                    end
                default: state <= IDLE;
            endcase
endmodule
